// File: rtl/izh_pkg.sv
// Shared FSM state encoding and Q16 model constants for the Izhikevich array core.
package izh_pkg;

  typedef logic [1:0] izh_state_t;

  localparam izh_state_t ST_IDLE  = 2'd0;
  localparam izh_state_t ST_RUN   = 2'd1;
  localparam izh_state_t ST_DRAIN = 2'd2;
  localparam izh_state_t ST_DONE  = 2'd3;

  localparam logic [31:0] K004_Q16 = 32'h0000_0A3D;
  localparam logic [31:0] K5_Q16   = 32'h0005_0000;
  localparam logic [31:0] K140_Q16 = 32'h008C_0000;

  // Re-express a Q16 constant with q fractional bits (all constants are positive).
  function automatic logic [63:0] q16_to_q(input logic [31:0] k16, input int q);
    if (q >= 16) return {32'd0, k16} << (q - 16);
    else return {32'd0, k16} >> (16 - q);
  endfunction

endpackage

// File: rtl/izh_neuron_update.sv
// Combinational Euler update of one Izhikevich neuron, including spike detection and reset.
// IZH_SATURATE_EN selects saturating instead of wrapping arithmetic.
module izh_neuron_update
  import izh_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic signed [N-1:0] v,
  input  logic signed [N-1:0] w,
  input  logic signed [N-1:0] i,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] c,
  input  logic signed [N-1:0] d,
  input  logic signed [N-1:0] v_th,
  input  logic signed [N-1:0] step,
  output logic signed [N-1:0] v_next,
  output logic signed [N-1:0] w_next,
  output logic                spike
);

  localparam logic signed [N-1:0] K004 = N'(q16_to_q(K004_Q16, Q));
  localparam logic signed [N-1:0] K5   = N'(q16_to_q(K5_Q16, Q));
  localparam logic signed [N-1:0] K140 = N'(q16_to_q(K140_Q16, Q));

  localparam logic signed [2*N-1:0] WIDE_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] WIDE_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [N-1:0]   NARROW_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]   NARROW_MIN = {1'b1, {(N-1){1'b0}}};

  // Every intermediate result is brought back to N bits here, clamped or wrapped.
  function automatic logic signed [N-1:0] fit(input logic signed [2*N-1:0] x);
`ifdef IZH_SATURATE_EN
    if (x > WIDE_MAX) return NARROW_MAX;
    if (x < WIDE_MIN) return NARROW_MIN;
`endif
    return x[N-1:0];
  endfunction

  function automatic logic signed [2*N-1:0] ext(input logic signed [N-1:0] x);
    return {{N{x[N-1]}}, x};
  endfunction

  function automatic logic signed [N-1:0] qmul(input logic signed [N-1:0] x,
                                               input logic signed [N-1:0] y);
    logic signed [2*N-1:0] p;
    p = ext(x) * ext(y);
    return fit(p >>> Q);
  endfunction

  function automatic logic signed [N-1:0] qadd(input logic signed [N-1:0] x,
                                               input logic signed [N-1:0] y);
    return fit(ext(x) + ext(y));
  endfunction

  function automatic logic signed [N-1:0] qsub(input logic signed [N-1:0] x,
                                               input logic signed [N-1:0] y);
    return fit(ext(x) - ext(y));
  endfunction

  logic signed [N-1:0] quad, lin, drive, dv, dw, v_new, w_new;

  always_comb begin
    quad   = qmul(qmul(K004, v), v);
    lin    = qmul(K5, v);
    drive  = qadd(qsub(qadd(qadd(quad, lin), K140), w), i);
    dv     = qmul(drive, step);
    dw     = qmul(qmul(a, qsub(qmul(b, v), w)), step);
    v_new  = qadd(v, dv);
    w_new  = qadd(w, dw);
    spike  = (v_new >= v_th);
    v_next = spike ? c : v_new;
    w_next = spike ? qadd(w_new, d) : w_new;
  end

endmodule

// File: rtl/izhikevich_array_core.sv
// Time-multiplexed Izhikevich neuron array: one Euler step over all neurons per start handshake.
// Define IZH_SATURATE_EN to saturate the datapath instead of wrapping modulo 2^N.
module izhikevich_array_core
  import izh_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 16,
  parameter int NEURONS = 4,
  parameter logic signed [N-1:0] V_INIT = N'(-64'sd65 <<< Q),
  parameter logic signed [N-1:0] W_INIT = N'(-64'sd13 <<< Q),
  localparam int AW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] c,
  input  logic signed [N-1:0] d,
  input  logic signed [N-1:0] v_th,
  input  logic signed [N-1:0] step,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic signed [N-1:0] i_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [N-1:0]        rd_v,
  output logic [N-1:0]        rd_w,
  output logic [NEURONS-1:0]  spikes,
  output logic                done,
  output logic                busy
);

  izh_state_t          state;
  logic [AW-1:0]       issue_idx;
  logic                handshake;

  logic signed [N-1:0] a_q, b_q, c_q, d_q, th_q, step_q;
  logic signed [N-1:0] v_mem [NEURONS];
  logic signed [N-1:0] w_mem [NEURONS];
  logic signed [N-1:0] i_mem [NEURONS];

  logic                wb_valid;
  logic [AW-1:0]       wb_addr;
  logic signed [N-1:0] wb_v, wb_w, wb_i;
  logic signed [N-1:0] upd_v, upd_w;
  logic                upd_spike;

  assign busy        = (state != ST_IDLE);
  assign start_ready = !busy;
  assign done        = (state == ST_DONE);
  assign handshake   = start_valid && start_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      issue_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: if (handshake) begin
          state     <= ST_RUN;
          issue_idx <= '0;
        end
        ST_RUN: begin
          if (int'(issue_idx) == NEURONS - 1) state <= ST_DRAIN;
          else issue_idx <= issue_idx + 1'b1;
        end
        ST_DRAIN: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Model constants are frozen for the whole step so port activity cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      th_q   <= '0;
      step_q <= '0;
    end else if (handshake) begin
      a_q    <= a;
      b_q    <= b;
      c_q    <= c;
      d_q    <= d;
      th_q   <= v_th;
      step_q <= step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_v     <= '0;
      wb_w     <= '0;
      wb_i     <= '0;
    end else begin
      wb_valid <= (state == ST_RUN);
      if (state == ST_RUN) begin
        wb_addr <= issue_idx;
        wb_v    <= v_mem[issue_idx];
        wb_w    <= w_mem[issue_idx];
        wb_i    <= i_mem[issue_idx];
      end
    end
  end

  izh_neuron_update #(.N(N), .Q(Q)) u_update (
    .v      (wb_v),
    .w      (wb_w),
    .i      (wb_i),
    .a      (a_q),
    .b      (b_q),
    .c      (c_q),
    .d      (d_q),
    .v_th   (th_q),
    .step   (step_q),
    .v_next (upd_v),
    .w_next (upd_w),
    .spike  (upd_spike)
  );

  // The issue stage captured i before this edge, so a same-cycle write only affects the next step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NEURONS; k++) begin
        v_mem[k] <= V_INIT;
        w_mem[k] <= W_INIT;
        i_mem[k] <= '0;
      end
    end else begin
      if (wb_valid) begin
        v_mem[wb_addr] <= upd_v;
        w_mem[wb_addr] <= upd_w;
      end
      if (i_we && int'(i_addr) < NEURONS) i_mem[i_addr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) spikes <= '0;
    else if (handshake) spikes <= '0;
    else if (wb_valid) spikes[wb_addr] <= upd_spike;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v <= '0;
      rd_w <= '0;
    end else if (int'(rd_addr) < NEURONS) begin
      rd_v <= v_mem[rd_addr];
      rd_w <= w_mem[rd_addr];
    end else begin
      rd_v <= '0;
      rd_w <= '0;
    end
  end

endmodule
